// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin packet arbiter: merges per-channel beat streams onto one AXI4-Stream master.
// Grant held for a whole packet, tdest = channel, beat watchdog; optional AXIS_ARB_PKT_COUNT_EN adds pkt_count.
module axis_rr_packet_arbiter #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned CH_BITS       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int unsigned MAX_PKT_BEATS = 256
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            ch_enable,
  input  logic [NUM_CHANNELS-1:0]            ch_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]            ch_last,
  output logic [NUM_CHANNELS-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]              stream_tdata,
  output logic [DATA_WIDTH/8-1:0]            stream_tkeep,
  output logic                               stream_tlast,
  output logic [CH_BITS-1:0]                 stream_tdest,
  output logic                               stream_tvalid,
  input  logic                               stream_tready,
  output logic [NUM_CHANNELS-1:0]            overrun_err,
  output logic                               busy
`ifdef AXIS_ARB_PKT_COUNT_EN
  ,
  output logic [NUM_CHANNELS*16-1:0]         pkt_count
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_BEATS + 1);
  localparam int unsigned CW    = CH_BITS + 1;
  localparam logic [CW-1:0] NCH = CW'(NUM_CHANNELS);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]              state, state_nxt;
  logic [CH_BITS-1:0]      grant, rr_ptr, arb_idx;
  logic                    arb_found;
  logic [CW-1:0]           cand;
  logic [NUM_CHANNELS-1:0] req;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    out_ready, accept, wd_hit, beat_last;
  logic [DATA_WIDTH-1:0]   ch_data_arr [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_unpack
    assign ch_data_arr[c] = ch_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req          = ch_valid & ch_enable;
  assign out_ready    = !stream_tvalid || stream_tready;
  assign stream_tkeep = '1;
  assign busy         = (state == S_LOCKED) || stream_tvalid;

  // Round-robin search starting one past the last served channel, wrapping modulo NUM_CHANNELS.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CW'(rr_ptr) + CW'(i);
      if (cand >= NCH) cand = cand - NCH;
      if (!arb_found && req[cand[CH_BITS-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[CH_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake; the watchdog forces tlast on the final permitted beat.
  always_comb begin
    state_nxt = state;
    ch_ready  = '0;
    accept    = 1'b0;
    wd_hit    = 1'b0;
    beat_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_found) state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        ch_ready[grant] = out_ready;
        accept          = ch_valid[grant] && out_ready;
        wd_hit          = (beat_cnt == CNT_W'(MAX_PKT_BEATS - 1));
        beat_last       = ch_last[grant] || wd_hit;
        if (accept && beat_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant         <= '0;
      rr_ptr        <= CH_BITS'(NUM_CHANNELS - 1);
      beat_cnt      <= '0;
      stream_tdata  <= '0;
      stream_tlast  <= 1'b0;
      stream_tdest  <= '0;
      stream_tvalid <= 1'b0;
      overrun_err   <= '0;
    end else begin
      if (state == S_IDLE && arb_found) grant <= arb_idx;
      if (accept) begin
        stream_tdata  <= ch_data_arr[grant];
        stream_tlast  <= beat_last;
        stream_tdest  <= grant;
        stream_tvalid <= 1'b1;
        if (beat_last) begin
          rr_ptr   <= grant;
          beat_cnt <= '0;
          if (!ch_last[grant]) overrun_err[grant] <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end else if (stream_tready) begin
        stream_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_ARB_PKT_COUNT_EN
  // Packets completed on the output, per source channel; truncated packets included.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (stream_tvalid && stream_tready && stream_tlast) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (stream_tdest == CH_BITS'(c))
          pkt_count[c*16 +: 16] <= pkt_count[c*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- N-channel round-robin arbiter that merges per-channel snoop packets onto one AXI4-Stream master.
- Sits between the per-channel AXI-to-stream capture units and the outbound stream port.
- The grant is locked for a whole packet (until `last`), and tdest carries the channel index.
- A beat-count watchdog force-terminates runaway packets.

Parameters:
- NUM_CHANNELS, 4, number of input channels (2..16).
- DATA_WIDTH, 128, stream data width in bits (multiple of 8).
- CH_BITS, $clog2(NUM_CHANNELS) (minimum 1), width of channel index / tdest.
- MAX_PKT_BEATS, 256, watchdog limit on beats per packet (≥2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ch_enable  in  NUM_CHANNELS  per-channel arbitration enable.
- ch_valid  in  NUM_CHANNELS  channel beat valid.
- ch_data  in  NUM_CHANNELS*DATA_WIDTH  channel beat data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_last  in  NUM_CHANNELS  channel beat is the packet end.
- ch_ready  out  NUM_CHANNELS  beat accepted from channel.
- stream_tdata  out  DATA_WIDTH  output data.
- stream_tkeep  out  DATA_WIDTH/8  always all ones.
- stream_tlast  out  1  output packet end.
- stream_tdest  out  CH_BITS  index of the source channel.
- stream_tvalid  out  1  output valid.
- stream_tready  in  1  output ready.
- overrun_err  out  NUM_CHANNELS  sticky: watchdog truncated a packet from channel i.
- busy  out  1  grant is locked, or the output register holds a beat.

Behaviour:
- Reset values:
  - stream_tvalid=0, stream_tlast=0, stream_tdata=0, stream_tdest=0.
  - ch_ready=0, overrun_err=0, busy=0.
  - State=IDLE, rr_ptr=NUM_CHANNELS-1 (so channel 0 wins first), beat_cnt=0.
- Reset mid-packet discards the held beat and the grant; no partial flush.
- FSM states: IDLE, LOCKED.
- IDLE:
  - req = ch_valid & ch_enable.
  - If req≠0, grant g = first set bit searching rr_ptr+1, rr_ptr+2, … modulo NUM_CHANNELS.
  - Register g and go to LOCKED next cycle. No beat is accepted in IDLE, so there is a 1-cycle bubble between packets.
  - If req==0, stay in IDLE.
- LOCKED:
  - ch_ready[g] = !stream_tvalid || stream_tready. All other ch_ready bits are 0.
  - The output register is a single stage: on ch_valid[g]&&ch_ready[g] it loads data/last, tdest=g, tvalid=1.
  - tvalid clears when stream_tready is high and no new beat loads.
  - Latency is 1 cycle from input handshake to stream_tvalid. Full throughput within a packet: 1 beat/cycle while tready=1.
  - Output data and tdest are stable while tvalid=1 and tready=0 (AXIS rule).
- Packet end:
  - When a beat with ch_last=1 is accepted: rr_ptr←g, beat_cnt←0, state←IDLE.
- ch_enable deasserted mid-packet does not cut the grant; the packet completes. The channel is excluded only from subsequent arbitration.
- Watchdog:
  - beat_cnt increments on each accepted beat in LOCKED.
  - On the MAX_PKT_BEATS-th accepted beat with ch_last=0, the output beat is forced to stream_tlast=1.
  - overrun_err[g] is set (sticky until reset), rr_ptr←g, and state←IDLE.
  - The channel's remaining beats are arbitrated later as a new packet.
- A channel deasserting ch_valid mid-packet inserts bubbles; the grant is held indefinitely (no idle timeout).
- Simultaneous requests resolve strictly by round-robin order from rr_ptr+1. With every enabled channel always requesting, the grant sequence is 0,1,…,N-1,0,…
- Channel indices ≥ NUM_CHANNELS do not exist. Wrap arithmetic is modulo NUM_CHANNELS, not 2^CH_BITS.
- busy = (state==LOCKED) || stream_tvalid.

Optional Feature:
- Macro AXIS_ARB_PKT_COUNT_EN.
- When defined: adds output pkt_count, width NUM_CHANNELS*16.
  - Holds per-channel 16-bit counters of packets completed on the output (incremented when a beat with stream_tlast=1 handshakes with stream_tready), including watchdog-truncated packets.
  - Counters wrap 0xFFFF→0 and clear on reset.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset and first grant: channels 0 and 2 valid simultaneously, 1-beat packets, tready=1 → channel 0 transmits first (tdest=0), then channel 2 (tdest=2); each stream_tvalid appears 1 cycle after its input handshake.
- Round-robin rotation: all 4 channels continuously offering 3-beat packets → tdest sequence 0,0,0,1,1,1,2,2,2,3,3,3,0…; each packet contiguous, tlast on every 3rd beat, exactly one idle output cycle between packets.
- Backpressure: tready held low for 5 cycles mid-packet → tdata/tdest/tlast stable; ch_ready[g]=0 while tvalid=1 and tready=0; no beat lost or duplicated across 8 beats.
- Watchdog: MAX_PKT_BEATS=4, channel 1 sends 6 beats with last only on beat 6 → beat 4 emitted with tlast=1, overrun_err=4'b0010; beats 5–6 emitted as a later 2-beat packet.
- Enable masking: ch_enable[1] cleared during channel 1's packet → packet completes; channel 1 is not granted again while channels 0 and 3 request; re-enabling restores its slot.
- Reset mid-packet: reset asserted on beat 2 of 5 → next cycle tvalid=0, ch_ready=0, busy=0; after release, channel 0 is granted first.
